// File: rtl/alu_ctrl_if.sv
// Request/result bundle between ID/EX and the ALU control sequencer.
interface alu_ctrl_if #(
  parameter int SEL_W = 5
);
  logic             in_valid;
  logic [1:0]       alu_op;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             funct7_0;
  logic             ex_flush;
  logic             in_ready;
  logic             out_valid;
  logic [SEL_W-1:0] alu_sel;
  logic             illegal;
  logic             stall;

  modport master (
    output in_valid, alu_op, funct3, funct7_5, funct7_0, ex_flush,
    input  in_ready, out_valid, alu_sel, illegal, stall
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7_5, funct7_0, ex_flush,
    output in_ready, out_valid, alu_sel, illegal, stall
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU operation decode with multi-cycle MUL/DIV occupancy sequencing.
// Define ALU_CTRL_MEXT_EN to enable M-extension decode and the MULW/DIVW wait states.
//   state | meaning
//   IDLE  | ready; single-cycle results are issued from here
//   MULW  | multiply in flight, counting down to its result cycle
//   DIVW  | divide/remainder in flight, counting down to its result cycle
module alu_ctrl_seq #(
  parameter int SEL_W   = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULW = 2'd1;
  localparam logic [1:0] S_DIVW = 2'd2;

  localparam logic [4:0] OP_AND  = 5'h00;
  localparam logic [4:0] OP_OR   = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h02;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_SUB  = 5'h06;
  localparam logic [4:0] OP_SLL  = 5'h07;
  localparam logic [4:0] OP_SRL  = 5'h08;
  localparam logic [4:0] OP_SRA  = 5'h09;
  localparam logic [4:0] OP_SLT  = 5'h0A;
  localparam logic [4:0] OP_SLTU = 5'h0B;

`ifdef ALU_CTRL_MEXT_EN
  localparam bit MEXT_EN = 1'b1;
`else
  localparam bit MEXT_EN = 1'b0;
`endif

  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] sel_q, sel_d;
  logic       ill_q, ill_d;
  logic       ov_q, ov_d;
  logic [4:0] dec_sel;
  logic       dec_ill;
  logic       busy;

  always_comb begin
    dec_sel = OP_ADD;
    dec_ill = 1'b0;
    case (bus.alu_op)
      2'b00: dec_sel = OP_ADD;
      2'b01: dec_sel = OP_SUB;
      default: begin
        if (bus.alu_op == 2'b10 && bus.funct7_0) begin
`ifdef ALU_CTRL_MEXT_EN
          dec_sel = {2'b10, bus.funct3};
`else
          dec_ill = 1'b1;
`endif
        end else begin
          case (bus.funct3)
            3'b000: dec_sel = (bus.alu_op == 2'b10 && bus.funct7_5) ? OP_SUB : OP_ADD;
            3'b001: dec_sel = OP_SLL;
            3'b010: dec_sel = OP_SLT;
            3'b011: dec_sel = OP_SLTU;
            3'b100: dec_sel = OP_XOR;
            3'b101: dec_sel = bus.funct7_5 ? OP_SRA : OP_SRL;
            3'b110: dec_sel = OP_OR;
            default: dec_sel = OP_AND;
          endcase
          // funct7_5 only has meaning for the add/sub and shift-right pairs
          if (bus.funct7_5 && bus.funct3 != 3'b000 && bus.funct3 != 3'b101) begin
            dec_ill = 1'b1;
            dec_sel = OP_ADD;
          end
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ill_d   = ill_q;
    ov_d    = 1'b0;
    if (bus.ex_flush) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            sel_d = dec_sel;
            ill_d = dec_ill;
            if (MEXT_EN && !dec_ill && dec_sel[4]) begin
              state_d = dec_sel[2] ? S_DIVW : S_MULW;
              cnt_d   = dec_sel[2] ? 6'(DIV_LAT - 1) : 6'(MUL_LAT - 1);
            end else begin
              ov_d = 1'b1;
            end
          end
        end
        S_MULW, S_DIVW: begin
          if (cnt_q == 6'd0) state_d = S_IDLE;
          else               cnt_d   = cnt_q - 6'd1;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      sel_q   <= OP_ADD;
      ill_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ill_q   <= ill_d;
      ov_q    <= ov_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign bus.in_ready  = !busy;
  // multi-cycle results issue in the wait state's final cycle, not a cycle later
  assign bus.out_valid = ov_q | (busy && cnt_q == 6'd0);
  assign bus.alu_sel   = SEL_W'(sel_q);
  assign bus.illegal   = ill_q;
`ifdef ALU_CTRL_MEXT_EN
  assign bus.stall     = busy;
`else
  assign bus.stall     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized bench for alu_ctrl_seq against an absolute-time occupancy model.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;
`ifdef ALU_CTRL_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  localparam logic [4:0] BASE [8] = '{5'h02, 5'h07, 5'h0A, 5'h0B, 5'h04, 5'h08, 5'h01, 5'h00};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_ctrl_if #(.SEL_W(5)) bus ();
  alu_ctrl_seq #(.SEL_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  // model state: expected outputs for the current cycle
  bit         m_busy   = 1'b0;
  bit         m_single = 1'b0;
  longint     m_end    = 0;
  longint     cyc      = 0;
  logic [4:0] exp_sel  = 5'h02;
  logic       exp_ill  = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
  endtask

  function automatic logic [5:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f5, input logic f0);
    if (op == 2'b00) return {1'b0, 5'h02};
    if (op == 2'b01) return {1'b0, 5'h06};
    if (op == 2'b10 && f0) return MEXT ? {1'b0, 5'h10 + 5'(f3)} : {1'b1, 5'h02};
    if (f5 && f3 != 3'd0 && f3 != 3'd5) return {1'b1, 5'h02};
    if (f3 == 3'd0) return {1'b0, (op == 2'b10 && f5) ? 5'h06 : 5'h02};
    if (f3 == 3'd5) return {1'b0, f5 ? 5'h09 : 5'h08};
    return {1'b0, BASE[f3]};
  endfunction

  function automatic int latency(input logic [5:0] r);
    if (r[5] || r[4:0] < 5'h10) return 1;
    if (r[4:0] < 5'h14) return MUL_LAT;
    return DIV_LAT;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_single = 1'b0;
      m_end    = 0;
      cyc      = 0;
      exp_sel  = 5'h02;
      exp_ill  = 1'b0;
    end else begin
      logic [5:0] r;
      int lat;
      m_single = 1'b0;
      if (m_busy) begin
        if (bus.ex_flush || cyc == m_end) m_busy = 1'b0;
      end else if (bus.in_valid && !bus.ex_flush) begin
        r       = ref_decode(bus.alu_op, bus.funct3, bus.funct7_5, bus.funct7_0);
        exp_sel = r[4:0];
        exp_ill = r[5];
        lat     = latency(r);
        if (lat == 1) m_single = 1'b1;
        else begin
          m_busy = 1'b1;
          m_end  = cyc + lat;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic exp_ov;
    exp_ov = m_single || (m_busy && cyc == m_end);
    check("in_ready",  int'(bus.in_ready),  int'(!m_busy));
    check("stall",     int'(bus.stall),     int'(m_busy));
    check("out_valid", int'(bus.out_valid), int'(exp_ov));
    check("alu_sel",   int'(bus.alu_sel),   int'(exp_sel));
    if (exp_ov) check("illegal", int'(bus.illegal), int'(exp_ill));
  end

  task automatic drive(input bit v, input logic [1:0] op, input logic [2:0] f3,
                       input bit f5, input bit f0, input bit fl);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.funct3   = f3;
    bus.funct7_5 = f5;
    bus.funct7_0 = f0;
    bus.ex_flush = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 2'b00, 3'd0, 0, 0, 0);
  endtask

  task automatic single(input string nm, input logic [1:0] op, input logic [2:0] f3,
                        input bit f5, input bit f0, input int e_sel, input int e_ill);
    drive(1, op, f3, f5, f0, 0);
    drive(0, 2'b00, 3'd0, 0, 0, 0);
    check({nm, "_ov"},  int'(bus.out_valid), 1);
    check({nm, "_sel"}, int'(bus.alu_sel),   e_sel);
    check({nm, "_ill"}, int'(bus.illegal),   e_ill);
  endtask

  initial begin
    int first_ov;
    int stalled;
    bus.in_valid = 0; bus.alu_op = 0; bus.funct3 = 0;
    bus.funct7_5 = 0; bus.funct7_0 = 0; bus.ex_flush = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #21 rst_n = 1'b1;
    idle(2);

    single("sub_r",  2'b10, 3'd0, 1, 0, 'h06, 0);
    single("sra_i",  2'b11, 3'd5, 1, 0, 'h09, 0);
    single("add_i",  2'b11, 3'd0, 1, 0, 'h02, 0);
    single("ill_or", 2'b10, 3'd6, 1, 0, 'h02, 1);
    single("sltu_r", 2'b10, 3'd3, 0, 0, 'h0B, 0);
    idle(1);

    // divide: latency, occupancy and selected code
    drive(1, 2'b10, 3'd4, 0, 1, 0);
    first_ov = 0;
    stalled  = 0;
    for (int n = 1; n <= 100 && first_ov == 0; n++) begin
      drive(0, 2'b00, 3'd0, 0, 0, 0);
      if (bus.stall && !bus.in_ready) stalled++;
      if (bus.out_valid) first_ov = n;
    end
    check("div_lat",   first_ov, MEXT ? 32 : 1);
    check("div_stall", stalled,  MEXT ? 32 : 0);
    check("div_sel",   int'(bus.alu_sel), MEXT ? 'h14 : 'h02);
    check("div_ill",   int'(bus.illegal), MEXT ? 0 : 1);
    idle(2);

    // multiply killed by ex_flush one cycle after accept
    drive(1, 2'b10, 3'd0, 0, 1, 0);
    drive(0, 2'b00, 3'd0, 0, 0, 1);
    check("mulfl_c1_ov", int'(bus.out_valid), MEXT ? 0 : 1);
    drive(1, 2'b00, 3'd0, 0, 0, 0);
    check("mulfl_c2_rdy", int'(bus.in_ready),  1);
    check("mulfl_c2_ov",  int'(bus.out_valid), 0);
    drive(0, 2'b00, 3'd0, 0, 0, 0);
    check("mulfl_add_ov",  int'(bus.out_valid), 1);
    check("mulfl_add_sel", int'(bus.alu_sel),   'h02);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3, 0) != 0, 2'($urandom), 3'($urandom),
            $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1,
            $urandom_range(15, 0) == 0);
    end

    for (int i = 0; i < 100 && m_busy; i++) drive(0, 2'b00, 3'd0, 0, 0, 0);
    check("drain_idle", int'(m_busy), 0);

    // asynchronous reset in the middle of a divide
    drive(1, 2'b10, 3'd7, 0, 1, 0);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ov",  int'(bus.out_valid), 0);
    check("rst_ill", int'(bus.illegal),   0);
    check("rst_stl", int'(bus.stall),     0);
    check("rst_rdy", int'(bus.in_ready),  1);
    check("rst_sel", int'(bus.alu_sel),   'h02);
    #3 rst_n = 1'b1;
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
